// File: rtl/rawsock_pkg.sv
// Shared types and constants for the raw-socket transmit arbiter.
package rawsock_pkg;

  localparam int RS_MIN_FRAME = 60;
  localparam int RS_MAX_FRAME = 1514;

  typedef logic [7:0]  rs_byte_t;
  typedef logic [10:0] rs_bcnt_t;
  typedef logic [15:0] rs_count_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_PAD,
    ST_SEND,
    ST_WAIT_ACK,
    ST_DRAIN
  } rs_state_t;

  function automatic rs_count_t sat_inc(input rs_count_t c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/rawsock_tx_arb_rr_pick.sv
// Round-robin selector: first set request after 'last', wrapping modulo N.
module rr_pick #(
  parameter int  N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] cand [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign cand[gi] = W'((int'(last) + gi + 1) % N);
  end

  // Scan from lowest priority up so the nearest candidate wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        idx   = cand[k];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rawsock_tx_arb.sv
// Arbitrates NUM_REQ byte-stream requesters onto one raw-socket transmit
// handle: pads short frames, aborts oversize frames, tracks send results.
module rawsock_tx_arb
  import rawsock_pkg::*;
#(
  parameter int  NUM_REQ   = 4,
  parameter int  MIN_FRAME = RS_MIN_FRAME,
  parameter int  MAX_FRAME = RS_MAX_FRAME,
  localparam int GW        = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   put_valid,
  output rs_byte_t               put_byte,
  output logic                   put_abort,
  output logic                   send_req,
  input  logic                   send_ack,
  input  logic                   send_ok,
  output logic                   busy,
  output logic [GW-1:0]          grant_id,
  output rs_count_t              sent_cnt,
  output rs_count_t              drop_cnt
);

  localparam rs_bcnt_t MIN_C = rs_bcnt_t'(MIN_FRAME);
  localparam rs_bcnt_t MAX_C = rs_bcnt_t'(MAX_FRAME);

  rs_state_t          state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  rs_bcnt_t           byte_cnt_q, byte_cnt_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               put_valid_q, put_valid_d;
  rs_byte_t           put_byte_q, put_byte_d;
  logic               put_abort_q, put_abort_d;
  logic               send_req_q, send_req_d;
  logic               busy_q, busy_d;
  rs_count_t          sent_cnt_q, sent_cnt_d;
  rs_count_t          drop_cnt_q, drop_cnt_d;

  logic [GW-1:0] pick_idx;
  logic          pick_found;
  logic          sel_valid, sel_last, accept, ready_en_d;
  rs_byte_t      sel_data;
  rs_bcnt_t      cnt_inc;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .last  (last_grant_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign sel_valid = req_valid[grant_q];
  assign sel_last  = req_last[grant_q];
  assign sel_data  = req_data[{grant_q, 3'b000} +: 8];
  assign accept    = sel_valid && req_ready_q[grant_q];
  assign cnt_inc   = byte_cnt_q + 11'd1;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    byte_cnt_d   = byte_cnt_q;
    put_valid_d  = 1'b0;
    put_byte_d   = 8'h00;
    put_abort_d  = 1'b0;
    send_req_d   = 1'b0;
    sent_cnt_d   = sent_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (accept) begin
          put_valid_d = 1'b1;
          put_byte_d  = sel_data;
          byte_cnt_d  = cnt_inc;
          if (sel_last) begin
            state_d = (cnt_inc < MIN_C) ? ST_PAD : ST_SEND;
          end else if (cnt_inc == MAX_C) begin
            put_abort_d = 1'b1;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_PAD: begin
        put_valid_d = 1'b1;
        byte_cnt_d  = cnt_inc;
        if (cnt_inc >= MIN_C) state_d = ST_SEND;
      end
      ST_SEND: begin
        send_req_d = 1'b1;
        state_d    = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // An ack coincident with the visible send_req pulse is premature.
        if (send_ack && !send_req_q) begin
          if (send_ok) sent_cnt_d = sat_inc(sent_cnt_q);
          else         drop_cnt_d = sat_inc(drop_cnt_q);
          last_grant_d = grant_q;
          byte_cnt_d   = '0;
          state_d      = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (accept && sel_last) begin
          drop_cnt_d   = sat_inc(drop_cnt_q);
          last_grant_d = grant_q;
          byte_cnt_d   = '0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is registered from the next state so it is valid the cycle it is seen.
  assign ready_en_d = (state_d == ST_STREAM) || (state_d == ST_DRAIN);
  assign busy_d     = (state_d != ST_IDLE);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready_d[gi] = ready_en_d && (grant_d == GW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      byte_cnt_q   <= '0;
      req_ready_q  <= '0;
      put_valid_q  <= 1'b0;
      put_byte_q   <= '0;
      put_abort_q  <= 1'b0;
      send_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      sent_cnt_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
      req_ready_q  <= req_ready_d;
      put_valid_q  <= put_valid_d;
      put_byte_q   <= put_byte_d;
      put_abort_q  <= put_abort_d;
      send_req_q   <= send_req_d;
      busy_q       <= busy_d;
      sent_cnt_q   <= sent_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign put_valid = put_valid_q;
  assign put_byte  = put_byte_q;
  assign put_abort = put_abort_q;
  assign send_req  = send_req_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;
  assign sent_cnt  = sent_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_rawsock_tx_arb.sv
// Scoreboard bench for rawsock_tx_arb: a frame-level reference model predicts
// the socket event stream; an independent monitor checks what the DUT emits.
module tb_rawsock_tx_arb;

  localparam int N        = 4;
  localparam int MINF     = 60;
  localparam int MAXF     = 1514;
  localparam int EV_BYTE  = 0;
  localparam int EV_ABORT = 1;
  localparam int EV_SEND  = 2;

  typedef struct packed { logic [7:0] d; logic last; logic first; } db_t;
  typedef struct packed { logic [1:0] kind; logic [7:0] d; logic [2:0] gid; } ev_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           put_valid;
  logic [7:0]     put_byte;
  logic           put_abort;
  logic           send_req;
  logic           send_ack;
  logic           send_ok;
  logic           busy;
  logic [1:0]     grant_id;
  logic [15:0]    sent_cnt;
  logic [15:0]    drop_cnt;

  rawsock_tx_arb #(.NUM_REQ(N), .MIN_FRAME(MINF), .MAX_FRAME(MAXF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .put_valid (put_valid),
    .put_byte  (put_byte),
    .put_abort (put_abort),
    .send_req  (send_req),
    .send_ack  (send_ack),
    .send_ok   (send_ok),
    .busy      (busy),
    .grant_id  (grant_id),
    .sent_cnt  (sent_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  db_t        drv_q [N][$];
  logic [N-1:0] acc;
  logic [7:0] mdat [N][$];
  int         mlen [N][$];
  bit         mok  [N][$];
  ev_t        exp_q [$];
  bit         ok_q [$];
  int         m_sent, m_drop, m_last;
  int         fr_bytes;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_frame(input int r, input int len, input bit ok);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom);
      drv_q[r].push_back({b, k == len - 1, k == 0});
      mdat[r].push_back(b);
    end
    mlen[r].push_back(len);
    mok[r].push_back(ok);
  endtask

  // Frame-level model: serve pending requesters round-robin, one whole frame each.
  task automatic plan();
    bit more;
    int pick, len;
    bit ok;
    logic [7:0] d;
    more = 1'b1;
    while (more) begin
      pick = -1;
      for (int k = 1; k <= N; k++)
        if (pick < 0 && mlen[(m_last + k) % N].size() > 0) pick = (m_last + k) % N;
      if (pick < 0) begin
        more = 1'b0;
      end else begin
        len = mlen[pick].pop_front();
        ok  = mok[pick].pop_front();
        for (int b = 0; b < len; b++) begin
          d = mdat[pick].pop_front();
          if (b < MAXF) exp_q.push_back({2'(EV_BYTE), d, 3'(pick)});
        end
        if (len > MAXF) begin
          exp_q.push_back({2'(EV_ABORT), 8'h00, 3'(pick)});
          m_drop = (m_drop < 65535) ? m_drop + 1 : m_drop;
        end else begin
          for (int b = len; b < MINF; b++) exp_q.push_back({2'(EV_BYTE), 8'h00, 3'(pick)});
          exp_q.push_back({2'(EV_SEND), 8'h00, 3'(pick)});
          ok_q.push_back(ok);
          if (ok) m_sent = (m_sent < 65535) ? m_sent + 1 : m_sent;
          else    m_drop = (m_drop < 65535) ? m_drop + 1 : m_drop;
        end
        m_last = pick;
      end
    end
  endtask

  task automatic pop_check(input int kind, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d, want none", kind);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, int'(e.kind));
      if (kind == EV_BYTE) begin
        check("put_byte", int'(d), int'(e.d));
        check("grant_id_in_frame", int'(grant_id), int'(e.gid));
        check("busy_in_frame", int'(busy), 1);
        fr_bytes++;
      end else begin
        $display("frame req=%0d bytes=%0d result=%s", e.gid, fr_bytes,
                 (kind == EV_SEND) ? "send" : "abort");
        fr_bytes = 0;
      end
    end
  endtask

  initial begin : monitor
    fr_bytes = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (put_valid) pop_check(EV_BYTE, put_byte);
        if (put_abort) pop_check(EV_ABORT, 8'h00);
        if (send_req)  pop_check(EV_SEND, 8'h00);
      end
    end
  end

  // Requester drivers: first byte of each frame is presented without a gap.
  initial begin : drivers
    db_t db;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    acc       = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        acc[i] = 1'b0;
        if (drv_q[i].size() > 0) begin
          db = drv_q[i][0];
          req_valid[i]       = db.first || ($urandom_range(3) != 0);
          req_data[i*8 +: 8] = db.d;
          req_last[i]        = db.last;
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
        acc[i] = req_valid[i] && req_ready[i];
      end
    end
  end

  // Socket wrapper: sometimes a premature ack with the wrong result, then the real one.
  initial begin : responder
    bit ok;
    send_ack = 1'b0;
    send_ok  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && send_req) begin
        if (ok_q.size() > 0) ok = ok_q.pop_front();
        else                 ok = 1'b1;
        if ($urandom_range(1) == 1) begin
          send_ack = 1'b1;
          send_ok  = !ok;
        end
        @(negedge clk);
        send_ack = 1'b0;
        send_ok  = 1'b0;
        repeat ($urandom_range(3)) @(negedge clk);
        send_ack = 1'b1;
        send_ok  = ok;
        @(negedge clk);
        send_ack = 1'b0;
        send_ok  = 1'b0;
      end
    end
  end

  function automatic bit drv_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (drv_q[i].size() > 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !busy && drv_empty()) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got %0d events pending, want 0", exp_q.size());
    end
    @(negedge clk);
    #1;
  endtask

  task automatic check_counts();
    check("sent_cnt", int'(sent_cnt), m_sent);
    check("drop_cnt", int'(drop_cnt), m_drop);
    check("grant_id_last", int'(grant_id), m_last);
    check("busy_idle", int'(busy), 0);
    check("req_ready_idle", int'(req_ready), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_put_valid", int'(put_valid), 0);
    check("rst_put_byte", int'(put_byte), 0);
    check("rst_put_abort", int'(put_abort), 0);
    check("rst_send_req", int'(send_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_sent_cnt", int'(sent_cnt), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    ok_q.delete();
    for (int i = 0; i < N; i++) begin
      drv_q[i].delete();
      mdat[i].delete();
      mlen[i].delete();
      mok[i].delete();
    end
    acc      = '0;
    m_sent   = 0;
    m_drop   = 0;
    m_last   = N - 1;
    fr_bytes = 0;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int total, k;
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;

    load_frame(0, 100, 1'b1); plan(); wait_idle(3000); check_counts();
    load_frame(2, 10, 1'b1);  plan(); wait_idle(1000); check_counts();
    load_frame(3, 5, 1'b0);   plan(); wait_idle(1000); check_counts();
    load_frame(1, 1600, 1'b1); load_frame(2, 30, 1'b1);
    plan(); wait_idle(5000); check_counts();
    load_frame(0, 1, 1'b1); load_frame(1, 1514, 1'b1); load_frame(2, 1515, 1'b1);
    plan(); wait_idle(8000); check_counts();

    // Reset in the middle of a long frame.
    load_frame(1, 200, 1'b1); plan();
    total = exp_q.size();
    k = 0;
    while (exp_q.size() > total - 20 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_start_timeout: got %0d events pending, want %0d", exp_q.size(), total - 20);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    clear_model();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;

    // All requesters contending: expected order 0,1,2,3,0.
    load_frame(3, 25, 1'b1); load_frame(1, 40, 1'b1); load_frame(2, 70, 1'b0);
    load_frame(0, 33, 1'b1); load_frame(0, 12, 1'b1);
    plan(); wait_idle(3000); check_counts();

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(1) == 1)
          repeat ($urandom_range(1, 2))
            load_frame(i, $urandom_range(1, 130), $urandom_range(3) != 0);
      plan(); wait_idle(4000); check_counts();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rawsock_tx_arb.md
RAWSOCK_TX_ARB -- requirements
Module: rawsock_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of frame requesters (2..8) sharing one raw-socket transmit handle.
REQ-002 Parameter MIN_FRAME, default 60: minimum byte count handed to the socket; shorter frames are zero-padded up to this count.
REQ-003 Parameter MAX_FRAME, default 1514: maximum byte count; longer frames are aborted.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester byte valid.
REQ-007 req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 req_last  in  NUM_REQ  per-requester last-byte-of-frame marker.
REQ-009 req_ready  out  NUM_REQ  per-requester byte accept.
REQ-010 put_valid  out  1  byte strobe to the socket wrapper (maps to dpiPutByte).
REQ-011 put_byte  out  8  byte for the socket wrapper.
REQ-012 put_abort  out  1  one-cycle pulse; the wrapper discards its partial frame.
REQ-013 send_req  out  1  one-cycle pulse; the wrapper sends the frame (maps to dpiSendFrame).
REQ-014 send_ack  in  1  the wrapper has completed the send.
REQ-015 send_ok  in  1  send result, qualified by send_ack.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 grant_id  out  $clog2(NUM_REQ)  current or most recent granted requester.
REQ-018 sent_cnt  out  16  frames sent successfully, saturating.
REQ-019 drop_cnt  out  16  frames aborted or failed, saturating.

Function
REQ-020 States: IDLE, STREAM, PAD, SEND, WAIT_ACK, DRAIN.
REQ-021 IDLE: when any req_valid is high, grant the first requester with req_valid set, searching round-robin from last_grant+1 modulo NUM_REQ; register the grant and enter STREAM on the next cycle.
REQ-022 In every state, req_ready is high only for the granted requester, and only in STREAM or DRAIN.
REQ-023 STREAM: each accept (valid and ready) yields put_valid=1 with put_byte equal to the accepted byte one cycle later (registered, latency 1); byte_cnt increments by 1.
REQ-024 STREAM, accept with req_last: if byte_cnt+1 < MIN_FRAME go to PAD, else go to SEND.
REQ-025 STREAM, accept without req_last: when byte_cnt+1 = MAX_FRAME, pulse put_abort and go to DRAIN.
REQ-026 PAD: output put_valid=1 and put_byte=0x00 once per cycle until byte_cnt = MIN_FRAME, then go to SEND.
REQ-027 SEND: send_req=1 for exactly one cycle, then go to WAIT_ACK.
REQ-028 WAIT_ACK: on send_ack, increment sent_cnt if send_ok, else increment drop_cnt; set last_grant to grant_id; clear byte_cnt; go to IDLE.
REQ-029 send_ack is ignored outside WAIT_ACK, including a send_ack in the same cycle as send_req.
REQ-030 DRAIN: accept and discard the granted requester's bytes, with no put_valid, until req_last is accepted; then increment drop_cnt, set last_grant, and go to IDLE.
REQ-031 A gap in req_valid during STREAM or DRAIN holds the state; there is no timeout.
REQ-032 A single-byte frame (req_last on the first byte) produces 1 data byte plus MIN_FRAME-1 zero pad bytes.
REQ-033 Both counters saturate at 0xFFFF.
REQ-034 byte_cnt is 11 bits wide and never wraps, because MAX_FRAME bounds it.

Reset
REQ-035 While rst_n is low: state=IDLE; all outputs 0; last_grant=NUM_REQ-1, so requester 0 has first priority; byte_cnt and both counters are 0.
REQ-036 A reset in the middle of a frame abandons the frame without a put_abort pulse; the wrapper is reset in the same domain.

Structure
REQ-037 A shared package rawsock_pkg holds the state enum, RS_MIN_FRAME, RS_MAX_FRAME, and the byte and count typedefs.
REQ-038 The round-robin priority selector is a sub-module, rr_pick (inputs: request vector and last grant; outputs: grant index and found flag).

Verification
REQ-039 Requester 0 sends a 100-byte frame -> 100 put_valid bytes matching the input, one send_req, sent_cnt=1 after send_ack with send_ok=1.
REQ-040 Requester 2 sends a 10-byte frame -> 10 data bytes followed by 50 bytes of 0x00, then send_req.
REQ-041 All 4 requesters hold req_valid continuously -> grant order 0,1,2,3,0, with no bytes interleaved within a frame.
REQ-042 A 1600-byte frame -> put_abort pulses after byte 1514, no send_req, drop_cnt=1, next requester then granted.
REQ-043 send_ack with send_ok=0 -> drop_cnt=1, sent_cnt unchanged; send_ack asserted in the same cycle as send_req is ignored.
REQ-044 rst_n asserted in the middle of STREAM -> all outputs 0 immediately; after release, requester 0 is granted first.
